// File: rtl/lbist_pkg.sv
// Shared types, default polynomials and the Galois shift helper for the LBIST sequencer.
package lbist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    FLUSH,
    COMPARE,
    DONE
  } lbist_state_e;

  localparam logic [31:0] LBIST_LFSR_POLY = 32'h80200003;
  localparam logic [31:0] LBIST_MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] LBIST_LFSR_SEED = 32'h00000001;

  // Widest register the shared helper can step; callers zero-extend into it.
  localparam int LBIST_MAX_W = 64;

  // One Galois step of a width-bit register held in the low bits of a 64-bit word:
  // shift left, and fold the polynomial back in when the old MSB was set.
  function automatic logic [LBIST_MAX_W-1:0] lfsr_next(
    input logic [LBIST_MAX_W-1:0] state,
    input logic [LBIST_MAX_W-1:0] poly,
    input int unsigned            width
  );
    logic [LBIST_MAX_W-1:0] w_mask;
    logic                   w_msb;
    w_msb  = state[6'(width - 1)];
    w_mask = (width >= LBIST_MAX_W) ? '1 :
             ((LBIST_MAX_W'(1) << width) - LBIST_MAX_W'(1));
    return ((state << 1) ^ (w_msb ? poly : '0)) & w_mask;
  endfunction

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register compacting CUT responses into one signature.
module lbist_misr
  import lbist_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(LBIST_MISR_POLY)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sig_o
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_shift;

  assign w_shift = WIDTH'(lfsr_next(LBIST_MAX_W'(r_sig), LBIST_MAX_W'(POLY), WIDTH));
  assign sig_o   = r_sig;

  // Clear wins over absorb so a new run always starts from an all-zero signature.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sig <= '0;
    end else if (clear_i) begin
      r_sig <= '0;
    end else if (en_i) begin
      r_sig <= w_shift ^ data_i;
    end
  end

endmodule

// File: rtl/lbist_controller.sv
// Logic-BIST sequencer: drives LFSR patterns into the core under test, compacts the
// delayed responses in a MISR and reports whether the final signature is the golden one.
module lbist_controller
  import lbist_pkg::*;
#(
  parameter int          PAT_WIDTH   = 32,
  parameter int          RESP_WIDTH  = 32,
  parameter int          N_PATTERNS  = 1024,
  parameter int          CUT_LATENCY = 2,
  parameter logic [31:0] LFSR_POLY   = LBIST_LFSR_POLY,
  parameter logic [31:0] MISR_POLY   = LBIST_MISR_POLY,
  parameter logic [31:0] LFSR_SEED   = LBIST_LFSR_SEED,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  test_mode_o,
  output logic [PAT_WIDTH-1:0]  pattern_o,
  input  logic [RESP_WIDTH-1:0] response_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  go_nogo_o,
  output logic [RESP_WIDTH-1:0] signature_o
);

  localparam int                    CNT_W        = $clog2(N_PATTERNS + 1);
  localparam logic [PAT_WIDTH-1:0]  C_LFSR_POLY  = PAT_WIDTH'(LFSR_POLY);
  localparam logic [PAT_WIDTH-1:0]  C_SEED_RAW   = PAT_WIDTH'(LFSR_SEED);
  // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [PAT_WIDTH-1:0]  C_SEED       = (C_SEED_RAW == '0) ? PAT_WIDTH'(1) : C_SEED_RAW;
  localparam logic [RESP_WIDTH-1:0] C_MISR_POLY  = RESP_WIDTH'(MISR_POLY);
  localparam logic [RESP_WIDTH-1:0] C_GOLDEN     = RESP_WIDTH'(GOLDEN_SIG);
  localparam logic [CNT_W-1:0]      C_LAST_PAT   = CNT_W'(N_PATTERNS - 1);
  localparam logic [3:0]            C_LAST_FLUSH = 4'(CUT_LATENCY - 1);

  lbist_state_e          r_state;
  lbist_state_e          w_state_next;
  logic                  r_start_q;
  logic                  r_armed;
  logic                  w_start_edge;
  logic [PAT_WIDTH-1:0]  r_lfsr;
  logic [PAT_WIDTH-1:0]  w_lfsr_next;
  logic [CNT_W-1:0]      r_pat_cnt;
  logic [3:0]            r_flush_cnt;
  logic                  w_in_run;
  logic                  w_misr_en;
  logic                  w_misr_clear;
  logic [RESP_WIDTH-1:0] w_misr_sig;
  logic                  r_match;
  logic [RESP_WIDTH-1:0] r_sig;
  logic                  r_done;
  logic                  w_test_mode;

  // r_armed stays low after reset until start_i has been seen low, so a request
  // already held high while reset is released does not look like a fresh edge.
  assign w_start_edge = start_i & ~r_start_q & r_armed;
  assign w_lfsr_next  = PAT_WIDTH'(lfsr_next(LBIST_MAX_W'(r_lfsr), LBIST_MAX_W'(C_LFSR_POLY), PAT_WIDTH));
  assign w_in_run     = (r_state == RUN);
  assign w_misr_clear = (r_state == INIT);
  assign w_test_mode  = (r_state == INIT) || (r_state == RUN) || (r_state == FLUSH);

  assign test_mode_o = w_test_mode;
  assign busy_o      = w_test_mode || (r_state == COMPARE);
  assign pattern_o   = r_lfsr;
  assign done_o      = r_done;
  assign go_nogo_o   = r_done & r_match;
  assign signature_o = r_sig;

  // State register; the async reset drops test_mode_o without waiting for a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic for the run sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_edge) w_state_next = INIT;
      INIT:    w_state_next = RUN;
      RUN:     if (r_pat_cnt == C_LAST_PAT) w_state_next = (CUT_LATENCY == 0) ? COMPARE : FLUSH;
      FLUSH:   if (r_flush_cnt == C_LAST_FLUSH) w_state_next = COMPARE;
      COMPARE: w_state_next = DONE;
      // Leave only once the result has been shown for at least one cycle.
      DONE:    if (!start_i && r_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Start request history used for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_start_q <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_start_q <= start_i;
      r_armed   <= r_armed | ~start_i;
    end
  end

  // Pattern generator and pattern/flush counters; the LFSR is frozen outside RUN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr      <= '0;
      r_pat_cnt   <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_lfsr      <= C_SEED;
          r_pat_cnt   <= '0;
          r_flush_cnt <= '0;
        end
        RUN: begin
          r_lfsr    <= w_lfsr_next;
          r_pat_cnt <= r_pat_cnt + CNT_W'(1);
        end
        FLUSH: begin
          r_flush_cnt <= r_flush_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Valid pipe: a 1 enters for every applied pattern and reaches the MISR enable
  // exactly when that pattern's response is on response_i.
  generate
    if (CUT_LATENCY == 0) begin : g_no_pipe
      assign w_misr_en = w_in_run;
    end else begin : g_pipe
      localparam int PIPE_W = CUT_LATENCY;
      logic [PIPE_W-1:0] r_vpipe;

      // Shift one stage per cycle; INIT flushes stale entries from an earlier run.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_vpipe <= '0;
        end else if (r_state == INIT) begin
          r_vpipe <= '0;
        end else begin
          r_vpipe <= (r_vpipe << 1) | PIPE_W'(w_in_run);
        end
      end

      assign w_misr_en = r_vpipe[PIPE_W-1];
    end
  endgenerate

  lbist_misr #(
    .WIDTH (RESP_WIDTH),
    .POLY  (C_MISR_POLY)
  ) u_misr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (w_misr_clear),
    .en_i    (w_misr_en),
    .data_i  (response_i),
    .sig_o   (w_misr_sig)
  );

  // Result capture; the verdict is cleared at INIT so a stale pass cannot leak into a new run.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_match <= 1'b0;
      r_sig   <= '0;
    end else if (r_state == INIT) begin
      r_match <= 1'b0;
    end else if (r_state == COMPARE) begin
      r_match <= (w_misr_sig == C_GOLDEN);
      r_sig   <= w_misr_sig;
    end
  end

  // done_o rises one cycle into DONE and falls on the same edge that returns to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DONE) && (w_state_next == DONE);
    end
  end

endmodule
